// File: rtl/serial_add_arb.sv
// -----------------------------------------------------------------------------
// serial_add_arb
//
// Shares one full-adder slice between two requesters. A round-robin arbiter
// accepts one request at a time; the sequencer then adds the granted operand
// pair bit-serially, LSB first, one bit per clock, and returns a WIDTH+1 bit
// result with a done pulse tagged by the owning requester.
//
// Handshake: reqN is a level request that the requester holds high, with aN/bN
// stable, until it sees the one-cycle gntN pulse. A req still high in the
// cycle after gntN is treated as a fresh request once the block is idle again.
// done is a one-cycle pulse; sum/done_id hold their values until the next done.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req0, a0, b0      requester 0 request and operands
//   req1, a1, b1      requester 1 request and operands
//   gnt0, gnt1        one-cycle accept pulses (never together)
//   busy              high while an operation is in RUN or DONE
//   done, done_id     result-valid pulse and owner of the current/last sum
//   sum               {carry_out, sum bits}
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_add_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH:0]   sum,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH:0]   sum_q, sum_d;

  // Shared full-adder slice working on the LSBs of the operand shifters.
  logic s_bit;
  logic c_next;
  logic pick1;

  always_comb begin
    s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_next = (a_sh_q[0] & b_sh_q[0]) | ((a_sh_q[0] ^ b_sh_q[0]) & carry_q);
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    pick1     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Requester 1 wins when it is alone, or on a tie when requester 0
          // was the last one served.
          pick1   = req1 & (~req0 | ~ptr_q);
          a_sh_d  = pick1 ? a1 : a0;
          b_sh_d  = pick1 ? b1 : b0;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          owner_d = pick1;
          ptr_d   = pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sh_d        = a_sh_q >> 1;
        b_sh_d        = b_sh_q >> 1;
        carry_d       = c_next;
        res_d[cnt_q]  = s_bit;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final bit: publish the sum including this cycle's bit and carry.
          sum_d     = {c_next, res_d};
          done_d    = 1'b1;
          done_id_d = owner_q;
          cnt_d     = '0;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign sum       = sum_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_arb.sv
module tb_serial_add_arb;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, done_id;
  logic [W:0]   sum;
  logic [1:0]   dbg_state;

  // WIDTH=1 instance for the single-bit boundary case
  logic         r_req0, r_req1;
  logic [0:0]   r_a0, r_b0, r_a1, r_b1;
  logic         r_gnt0, r_gnt1, r_busy, r_done, r_done_id;
  logic [1:0]   r_sum;
  logic [1:0]   r_dbg_state;

  serial_add_arb #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .dbg_state(dbg_state)
  );

  serial_add_arb #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0(r_req0), .a0(r_a0), .b0(r_b0),
    .req1(r_req1), .a1(r_a1), .b1(r_b1),
    .gnt0(r_gnt0), .gnt1(r_gnt1), .busy(r_busy), .done(r_done),
    .done_id(r_done_id), .sum(r_sum), .dbg_state(r_dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // {owner, expected sum} per accepted operation, in acceptance order
  logic [W+1:0] exp_q[$];

  // Reference: an operation occupies the adder for W+2 edges counted from
  // the accepting edge; done shows after the W-th edge following acceptance.
  int         m_left;
  logic       m_ptr;
  logic       e_gnt0, e_gnt1, e_busy, e_done, e_done_id;
  logic [W:0] e_sum;

  int hold0, hold1;          // extra grants for which the requester keeps req
  int t_gnt, t_done, busy_cnt;
  int g_q[$];                // cycles at which a grant was observed

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic       pick;
    logic [W+1:0] ent;
    if (rst) begin
      m_left = 0; m_ptr = 1'b1;
      e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_done = 0; e_done_id = 0; e_sum = '0;
      exp_q.delete();
    end else begin
      e_gnt0 = 0; e_gnt1 = 0; e_done = 0;
      if (m_left == 0) begin
        if (req0 || req1) begin
          pick   = (req0 && req1) ? ~m_ptr : req1;
          m_ptr  = pick;
          e_gnt0 = ~pick;
          e_gnt1 = pick;
          m_left = W + 1;
          if (pick) exp_q.push_back({1'b1, {1'b0, a1} + {1'b0, b1}});
          else      exp_q.push_back({1'b0, {1'b0, a0} + {1'b0, b0}});
        end
      end else begin
        m_left--;
        if (m_left == 1) begin
          e_done = 1;
          if (exp_q.size() > 0) begin
            ent       = exp_q.pop_front();
            e_done_id = ent[W+1];
            e_sum     = ent[W:0];
          end
        end
      end
      e_busy = (m_left != 0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("gnt0",    32'(gnt0),    32'(e_gnt0));
    check("gnt1",    32'(gnt1),    32'(e_gnt1));
    check("busy",    32'(busy),    32'(e_busy));
    check("done",    32'(done),    32'(e_done));
    check("done_id", 32'(done_id), 32'(e_done_id));
    check("sum",     32'(sum),     32'(e_sum));
    check("gnt_excl",  32'(gnt0 & gnt1), 32'(0));
    check("gnt_done",  32'(done & (gnt0 | gnt1)), 32'(0));
    if (gnt0 || gnt1) begin t_gnt = cyc; g_q.push_back(cyc); end
    if (done) t_done = cyc;
    if (busy) busy_cnt++;
    if (gnt0) begin if (hold0 > 0) hold0--; else req0 = 0; end
    if (gnt1) begin if (hold1 > 0) hold1--; else req1 = 0; end
  endtask

  task automatic issue0(input int a, input int b);
    a0 = W'(a); b0 = W'(b); req0 = 1;
  endtask

  task automatic issue1(input int a, input int b);
    a1 = W'(a); b1 = W'(b); req1 = 1;
  endtask

  initial begin
    rst = 1; req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    r_req0 = 0; r_req1 = 0; r_a0 = '0; r_b0 = '0; r_a1 = '0; r_b1 = '0;
    hold0 = 0; hold1 = 0; t_gnt = 0; t_done = 0; busy_cnt = 0;
    m_left = 0; m_ptr = 1; e_gnt0 = 0; e_gnt1 = 0; e_busy = 0;
    e_done = 0; e_done_id = 0; e_sum = '0;

    // reset
    cycle(); cycle();
    rst = 0;
    cycle();

    // single requester 0: 7+5
    busy_cnt = 0;
    issue0(7, 5);
    repeat (8) cycle();
    check("lat_done", 32'(t_done - t_gnt), 32'(W));
    check("busy_len", 32'(busy_cnt), 32'(W + 1));

    // requester 1: F+F, with req0 raised mid-operation
    issue1(15, 15);
    cycle(); cycle();
    issue0(2, 3);
    repeat (14) cycle();

    // both requesting at first accept after reset; held for alternation
    rst = 1; cycle(); rst = 0;
    issue0(1, 1); issue1(2, 3);
    hold0 = 2; hold1 = 2;
    repeat (6 * (W + 2) + 2) cycle();
    hold0 = 0; hold1 = 0; req0 = 0; req1 = 0;
    repeat (W + 3) cycle();

    // reset two cycles into RUN, then a fresh operation
    issue0(5, 6);
    cycle(); cycle(); cycle();
    rst = 1; req0 = 0;
    cycle();
    rst = 0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_sum",  32'(sum),  32'(0));
    issue0(3, 1);
    repeat (8) cycle();

    // boundary operands
    issue0(0, 0);
    repeat (8) cycle();
    issue1(8, 8);
    repeat (8) cycle();

    // WIDTH=1: 1+1, then 1+0 from requester 1
    r_a0 = 1'b1; r_b0 = 1'b1; r_req0 = 1;
    cycle();
    check("w1_gnt0", 32'(r_gnt0), 32'(1));
    check("w1_busy", 32'(r_busy), 32'(1));
    check("w1_ndone", 32'(r_done), 32'(0));
    r_req0 = 0;
    cycle();
    check("w1_done", 32'(r_done), 32'(1));
    check("w1_sum",  32'(r_sum),  32'(2));
    check("w1_id",   32'(r_done_id), 32'(0));
    cycle();
    check("w1_idle", 32'(r_busy), 32'(0));
    check("w1_hold", 32'(r_sum),  32'(2));
    r_a1 = 1'b1; r_b1 = 1'b0; r_req1 = 1;
    cycle();
    check("w1_gnt1", 32'(r_gnt1), 32'(1));
    r_req1 = 0;
    cycle();
    check("w1_sum1", 32'(r_sum), 32'(1));
    check("w1_id1",  32'(r_done_id), 32'(1));
    cycle();

    // back-to-back: req0 held continuously
    g_q.delete();
    issue0(9, 4);
    hold0 = 1000;
    repeat (3 * (W + 2) + 2) cycle();
    check("b2b_cnt", 32'(g_q.size() >= 3), 32'(1));
    for (int i = 1; i < g_q.size(); i++)
      check("b2b_space", 32'(g_q[i] - g_q[i-1]), 32'(W + 2));
    hold0 = 0; req0 = 0;
    repeat (W + 3) cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!req0 && $urandom_range(0, 3) == 0) begin
        issue0(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
        hold0 = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      if (!req1 && $urandom_range(0, 3) == 0) begin
        issue1(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
        hold1 = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      cycle();
    end

    // drain: every accepted operation must have completed
    hold0 = 0; hold1 = 0; req0 = 0; req1 = 0;
    repeat (2 * (W + 2) + 2) cycle();
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
